// File: rtl/data_sram_ctrl.sv
// Byte-lane SRAM controller: req/ack handshake, WAIT_CYCLES wait states, out-of-range detection.
// One access per WAIT_CYCLES+3 cycles; inputs are ignored from acceptance until the return to IDLE.
module data_sram_ctrl #(
  parameter int DATA_W      = 32,
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_i,
  input  logic                we_i,
  input  logic [DATA_W/8-1:0] sel_i,
  input  logic [31:0]         addr_i,
  input  logic [DATA_W-1:0]   data_i,
  output logic                ack_o,
  output logic                err_o,
  output logic [DATA_W-1:0]   data_o
);

  localparam int LANES  = DATA_W / 8;
  localparam int ALIGN  = $clog2(LANES);
  localparam int DEPTH  = 2 ** DEPTH_LOG2;
  localparam int IDX_HI = DEPTH_LOG2 + ALIGN;

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                we_q;
  logic [LANES-1:0]    sel_q;
  logic [31:0]         addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic                capture;
  logic                access;
  logic                oor;
  logic [DEPTH_LOG2-1:0] idx;
  logic [DATA_W-1:0]   rword;

  logic [7:0] mem [LANES][DEPTH];

  assign idx = addr_q[IDX_HI-1:ALIGN];
  assign oor = (addr_q >> IDX_HI) != 32'd0;

  always_comb begin
    rword = '0;
    for (int k = 0; k < LANES; k++) rword[8*k +: 8] = mem[k][idx];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    access  = 1'b0;
    unique case (state_q)
      IDLE: if (req_i) begin
        state_d = WAIT;
        cnt_d   = 4'(WAIT_CYCLES);
        capture = 1'b1;
      end
      WAIT: if (cnt_q != 4'd0) begin
        cnt_d = cnt_q - 4'd1;
      end else begin
        access  = 1'b1;
        state_d = ACK;
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    err_d   = err_q;
    rdata_d = rdata_q;
    if (access) begin
      err_d = oor;
      if (oor)        rdata_d = '0;
      else if (!we_q) rdata_d = rword;
    end else if (state_q == ACK) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Captured request fields define the whole access; they need no reset.
  always_ff @(posedge clk) begin
    if (capture) begin
      we_q    <= we_i;
      sel_q   <= sel_i;
      addr_q  <= addr_i;
      wdata_q <= data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && access && we_q && !oor) begin
      for (int k = 0; k < LANES; k++) begin
        if (sel_q[k]) mem[k][idx] <= wdata_q[8*k +: 8];
      end
    end
  end

  assign ack_o  = (state_q == ACK);
  assign err_o  = err_q;
  assign data_o = rdata_q;

endmodule

// File: tb/tb_data_sram_ctrl.sv
// Bench for data_sram_ctrl: directed scenarios plus random accesses against a word-array model.
module tb_data_sram_ctrl;

  localparam int DW = 32;
  localparam int DL = 6;
  localparam int WC = 3;
  localparam int LN = DW / 8;
  localparam int AL = 2;
  localparam int NW = 2 ** DL;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_i;
  logic          we_i;
  logic [LN-1:0] sel_i;
  logic [31:0]   addr_i;
  logic [DW-1:0] data_i;
  logic          ack_o;
  logic          err_o;
  logic [DW-1:0] data_o;

  data_sram_ctrl #(.DATA_W(DW), .DEPTH_LOG2(DL), .WAIT_CYCLES(WC)) u_dut (
    .clk    (clk),
    .rst    (rst),
    .req_i  (req_i),
    .we_i   (we_i),
    .sel_i  (sel_i),
    .addr_i (addr_i),
    .data_i (data_i),
    .ack_o  (ack_o),
    .err_o  (err_o),
    .data_o (data_o)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mdl [NW];
  logic [DW-1:0] exp_dout;
  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One full transaction; inputs are scrambled after acceptance to show they are ignored.
  task automatic access(input logic w, input logic [LN-1:0] s, input logic [31:0] a,
                        input logic [DW-1:0] d, input string tag);
    int   lat;
    bit   got;
    logic oor;
    int   idx;
    @(negedge clk);
    we_i = w; sel_i = s; addr_i = a; data_i = d; req_i = 1'b1;
    @(posedge clk); #1;
    we_i = ~w; sel_i = LN'($urandom); addr_i = $urandom; data_i = DW'($urandom);
    lat = 0; got = 1'b0;
    while (!got && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (ack_o === 1'b1) got = 1'b1;
    end
    req_i = 1'b0;
    oor = (a >> (DL + AL)) != 32'd0;
    idx = int'(a[DL+AL-1:AL]);
    if (oor) exp_dout = '0;
    else if (w) begin
      for (int k = 0; k < LN; k++) if (s[k]) mdl[idx][8*k +: 8] = d[8*k +: 8];
    end else exp_dout = mdl[idx];
    check({tag, "/ack_latency"}, 64'(lat), 64'(WC + 1));
    check({tag, "/err"}, 64'(err_o), 64'(oor));
    check({tag, "/data"}, 64'(data_o), 64'(exp_dout));
    @(posedge clk); #1;
    check({tag, "/ack_single"}, 64'(ack_o), 64'd0);
    check({tag, "/err_clear"}, 64'(err_o), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int acks [$];
    int nack;
    int first, gap;
    logic [31:0] ra;

    rst = 1'b1; req_i = 1'b0; we_i = 1'b0; sel_i = '0; addr_i = '0; data_i = '0;
    exp_dout = '0;
    #12;
    check("reset/ack", 64'(ack_o), 64'd0);
    check("reset/err", 64'(err_o), 64'd0);
    check("reset/data", 64'(data_o), 64'd0);
    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < NW; i++) access(1'b1, '1, 32'(i * LN), DW'($urandom), "init");

    access(1'b1, 4'hF, 32'h10, 32'hDEADBEEF, "wr_full");
    access(1'b0, 4'hF, 32'h10, 32'h0, "rd_full");
    check("rd_deadbeef", 64'(data_o), 64'hDEADBEEF);
    access(1'b1, 4'h5, 32'h10, 32'h00AA0055, "wr_lanes02");
    check("wr_keeps_dout", 64'(data_o), 64'hDEADBEEF);
    access(1'b0, 4'h0, 32'h10, 32'h0, "rd_sel0");
    check("rd_merged", 64'(data_o), 64'hDEAABE55);
    access(1'b1, 4'h0, 32'h10, 32'hFFFFFFFF, "wr_nosel");
    access(1'b0, 4'hF, 32'h13, 32'h0, "rd_unaligned");
    check("rd_after_nosel", 64'(data_o), 64'hDEAABE55);

    access(1'b1, 4'hF, 32'h1000, 32'h12345678, "oor_wr");
    access(1'b0, 4'hF, 32'h1000, 32'h0, "oor_rd");
    access(1'b0, 4'hF, 32'h0, 32'h0, "rd_word0");
    access(1'b0, 4'hF, 32'hFC, 32'h0, "rd_top");
    access(1'b0, 4'hF, 32'h100, 32'h0, "oor_edge");

    // Request held high: two reads back to back, gap of WC+3 edges between acks.
    @(negedge clk);
    we_i = 1'b0; sel_i = 4'hF; addr_i = 32'h10; req_i = 1'b1;
    for (int e = 1; e <= 2 * (WC + 3); e++) begin
      @(posedge clk); #1;
      if (ack_o === 1'b1) acks.push_back(e);
    end
    req_i = 1'b0;
    first = (acks.size() > 0) ? acks[0] : -1;
    gap   = (acks.size() > 1) ? acks[1] - acks[0] : -1;
    check("held/ack_count", 64'(acks.size()), 64'd2);
    check("held/first_ack", 64'(first), 64'(WC + 2));
    check("held/ack_gap", 64'(gap), 64'(WC + 3));
    exp_dout = mdl[4];
    check("held/data", 64'(data_o), 64'(exp_dout));
    @(posedge clk); #1;

    // Reset during WAIT aborts the write.
    @(negedge clk);
    we_i = 1'b1; sel_i = 4'hF; addr_i = 32'h20; data_i = ~mdl[8]; req_i = 1'b1;
    @(posedge clk); #1;
    req_i = 1'b0;
    @(posedge clk);
    @(negedge clk); rst = 1'b1; #1;
    check("abort/ack", 64'(ack_o), 64'd0);
    check("abort/err", 64'(err_o), 64'd0);
    check("abort/data", 64'(data_o), 64'd0);
    @(negedge clk); rst = 1'b0;
    exp_dout = '0;
    nack = 0;
    for (int e = 0; e < WC + 4; e++) begin
      @(posedge clk); #1;
      if (ack_o === 1'b1) nack++;
    end
    check("abort/no_ack", 64'(nack), 64'd0);
    access(1'b0, 4'hF, 32'h20, 32'h0, "abort/readback");

    for (int n = 0; n < 80; n++) begin
      case ($urandom_range(0, 9))
        0:       ra = $urandom;
        1:       ra = 32'h100 + 32'($urandom_range(0, 255));
        default: ra = 32'($urandom_range(0, 255));
      endcase
      access(1'($urandom_range(0, 1)), LN'($urandom), ra, DW'($urandom), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
